// File: rtl/seg_scan_driver.sv
// Four-digit 7-segment scan controller with blanking gaps between digits
// and a staged update that is applied only at frame boundaries.
module seg_scan_driver #(
    parameter int DIV = 4,
    parameter int GAP = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic [15:0] din,
    input  logic        lzb,
    output logic        rdy,
    output logic [1:0]  digit_sel,
    output logic [3:0]  an_n,
    output logic [3:0]  bcd,
    output logic        blank,
    output logic        frame_tick,
    output logic        err
);
    localparam int MAXC = (DIV > GAP) ? DIV : GAP;
    localparam int CW = $clog2(MAXC + 1);
    localparam logic [CW-1:0] DIV_LAST = CW'(DIV - 1);
    localparam logic [CW-1:0] GAP_LAST = CW'(GAP - 1);

    typedef enum logic {
        S_GAP,
        S_SHOW
    } state_t;

    state_t        state;
    state_t        state_nx;
    logic [CW-1:0] cnt;
    logic [CW-1:0] cnt_nx;
    logic [1:0]    sel_nx;
    logic [15:0]   disp;
    logic [15:0]   pend_data;
    logic          pend;
    logic          frame_start;
    logic          accept;
    logic [3:0]    nib [4];
    logic [3:0]    inv;
    logic [3:0]    lz;
    logic [3:0]    sup;

    assign accept = load && !pend;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= S_GAP;
            cnt       <= '0;
            digit_sel <= 2'd3;
            disp      <= '0;
            pend_data <= '0;
            pend      <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            digit_sel <= sel_nx;
            // A pending update wins over a new load at the frame edge
            if (frame_start && pend) begin
                disp <= pend_data;
                pend <= 1'b0;
            end else if (accept) begin
                pend_data <= din;
                pend      <= 1'b1;
            end
        end
    end

    always_comb begin
        state_nx    = state;
        cnt_nx      = cnt + CW'(1);
        sel_nx      = digit_sel;
        frame_start = 1'b0;
        unique case (state)
            S_GAP: begin
                if (cnt == GAP_LAST) begin
                    state_nx    = S_SHOW;
                    cnt_nx      = '0;
                    sel_nx      = digit_sel + 2'd1;
                    frame_start = (digit_sel == 2'd3);
                end
            end
            S_SHOW: begin
                if (cnt == DIV_LAST) begin
                    state_nx = S_GAP;
                    cnt_nx   = '0;
                end
            end
            default: ;
        endcase
    end

    // Leading-zero run: digit i is in it when digits 3..i are all zero
    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nib[i] = disp[4*i +: 4];
            inv[i] = nib[i] > 4'd9;
        end
        lz[3] = (nib[3] == 4'd0);
        lz[2] = lz[3] && (nib[2] == 4'd0);
        lz[1] = lz[2] && (nib[1] == 4'd0);
        lz[0] = 1'b0;
        sup   = inv | ({4{lzb}} & lz);
    end

    assign blank      = (state == S_GAP) || sup[digit_sel];
    assign an_n       = blank ? 4'hF : ~(4'b0001 << digit_sel);
    assign bcd        = blank ? 4'h0 : nib[digit_sel];
    assign frame_tick = (state == S_SHOW) && (digit_sel == 2'd0) && (cnt == '0);
    assign err        = |inv;
    assign rdy        = ~pend;

endmodule

// File: tb/tb_seg_scan_driver.sv
// Bench for seg_scan_driver: loads go into a scoreboard queue and are
// popped at the frame start where they should appear on the display.
module tb_seg_scan_driver;
    localparam int DIV   = 4;
    localparam int GAP   = 1;
    localparam int PER   = DIV + GAP;
    localparam int FRAME = 4 * PER;

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        load  = 1'b0;
    logic        lzb   = 1'b0;
    logic [15:0] din   = '0;
    logic        rdy;
    logic [1:0]  digit_sel;
    logic [3:0]  an_n;
    logic [3:0]  bcd;
    logic        blank;
    logic        frame_tick;
    logic        err;

    seg_scan_driver #(.DIV(DIV), .GAP(GAP)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .load       (load),
        .din        (din),
        .lzb        (lzb),
        .rdy        (rdy),
        .digit_sel  (digit_sel),
        .an_n       (an_n),
        .bcd        (bcd),
        .blank      (blank),
        .frame_tick (frame_tick),
        .err        (err)
    );

    always #5 clk = ~clk;

    int          n_chk    = 0;
    int          n_pass   = 0;
    int          k        = 0;
    logic        exp_pend = 1'b0;
    logic [15:0] cur      = '0;
    logic [15:0] sb [$];

    task automatic check(input string tag, input logic [15:0] got,
                         input logic [15:0] exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    function automatic logic next_fs();
        return (k + 1 >= GAP) && (((k + 1 - GAP) % FRAME) == 0);
    endfunction

    task automatic check_outputs();
        int          p;
        int          ds;
        logic        show;
        logic        ft;
        logic        zrun;
        logic        sup;
        logic        bl;
        logic        err_e;
        logic [3:0]  nb;
        logic [3:0]  an_e;
        logic [3:0]  bcd_e;
        if (k < GAP) begin
            ds   = 3;
            show = 1'b0;
            ft   = 1'b0;
        end else begin
            p    = (k - GAP) % FRAME;
            ds   = p / PER;
            show = (p % PER) < DIV;
            ft   = (p == 0);
        end
        nb   = cur[4*ds +: 4];
        zrun = 1'b1;
        for (int j = ds; j < 4; j++)
            if (cur[4*j +: 4] != 4'd0) zrun = 1'b0;
        sup   = (nb > 4'd9) || (lzb && ds != 0 && zrun);
        bl    = !show || sup;
        an_e  = bl ? 4'hF : ~(4'b0001 << ds);
        bcd_e = bl ? 4'h0 : nb;
        err_e = 1'b0;
        for (int j = 0; j < 4; j++)
            if (cur[4*j +: 4] > 4'd9) err_e = 1'b1;
        check("digit_sel", 16'(digit_sel), 16'(ds));
        check("an_n", 16'(an_n), 16'(an_e));
        check("bcd", 16'(bcd), 16'(bcd_e));
        check("blank", 16'(blank), 16'(bl));
        check("frame_tick", 16'(frame_tick), 16'(ft));
        check("rdy", 16'(rdy), 16'(!exp_pend));
        check("err", 16'(err), 16'(err_e));
    endtask

    task automatic tick(input logic ld, input logic [15:0] d);
        logic fs;
        logic take;
        load = ld;
        din  = d;
        fs   = next_fs();
        @(posedge clk);
        k++;
        take = 1'b0;
        if (fs && exp_pend) begin
            exp_pend = 1'b0;
            take     = 1'b1;
        end else if (ld && !exp_pend) begin
            sb.push_back(d);
            exp_pend = 1'b1;
        end
        @(negedge clk);
        load = 1'b0;
        if (take && sb.size() != 0) cur = sb.pop_front();
        check_outputs();
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) tick(1'b0, 16'h0);
    endtask

    // Stop with the next edge being a frame start
    task automatic align();
        for (int i = 0; i < FRAME && !next_fs(); i++) tick(1'b0, 16'h0);
    endtask

    task automatic to_digit2_show();
        for (int i = 0; i < FRAME; i++) begin
            if (k >= GAP && ((k - GAP) % FRAME) / PER == 2 &&
                ((k - GAP) % PER) < DIV) break;
            tick(1'b0, 16'h0);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        tick(1'b0, 16'h0);

        tick(1'b1, 16'h1234);
        run(2 * FRAME);

        lzb = 1'b1;
        tick(1'b1, 16'h0050);
        run(2 * FRAME);
        tick(1'b1, 16'h0000);
        run(2 * FRAME);
        lzb = 1'b0;

        tick(1'b1, 16'h12A4);
        run(2 * FRAME);
        tick(1'b1, 16'h1234);
        run(2 * FRAME);

        align();
        tick(1'b0, 16'h0);
        tick(1'b1, 16'h1111);
        tick(1'b0, 16'h0);
        tick(1'b1, 16'h2222);
        run(2 * FRAME);

        align();
        tick(1'b1, 16'h5678);
        run(FRAME + 5);
        align();
        tick(1'b0, 16'h0);
        tick(1'b1, 16'h4321);
        run(2 * FRAME);

        align();
        tick(1'b0, 16'h0);
        tick(1'b1, 16'h9876);
        to_digit2_show();
        #2;
        rst_n = 1'b0;
        #1;
        k        = 0;
        cur      = '0;
        exp_pend = 1'b0;
        sb.delete();
        check_outputs();
        @(negedge clk);
        check_outputs();
        rst_n = 1'b1;
        run(2 * FRAME);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
